// File: rtl/pdm_mic_clk_ctrl.sv
// pdm_mic_clk_ctrl: PDM microphone clock generator with stereo bit capture.
// The system clock is divided by 2*half_div, where half_div is programmable at
// runtime. New ratios take effect only at the start of a high phase, so the
// mic clock never glitches. The mic data pin is resynchronised, then sampled:
// the right channel at the end of the high phase, the left channel at the end
// of the low phase.
module pdm_mic_clk_ctrl #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 16,
    parameter int MIN_HALF     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             cfg_load,
    output logic             cfg_busy,
    output logic             pdm_clk,
    output logic             rise_stb,
    output logic             fall_stb,
    input  logic             pdm_data,
    output logic             data_r,
    output logic             data_l,
    output logic             pair_valid
);

    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] MIN_H = CNT_W'(MIN_HALF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] pend_q;
    logic             busy_q;
    logic             clk_q;
    logic             rise_q;
    logic             fall_q;
    logic             dr_q;
    logic             dl_q;
    logic             pv_q;
    logic             sync1_q;
    logic             sync2_q;

    logic [CNT_W-1:0] cfg_clamped;
    logic [CNT_W-1:0] half_d;
    logic             phase_end;
    logic             start;

    // Too-small ratios (including 0) are raised to the minimum legal half-period.
    assign cfg_clamped = (cfg_half < MIN_H) ? MIN_H : cfg_half;
    // A load landing on the apply cycle bypasses pending and takes effect at once.
    assign half_d      = cfg_load ? cfg_clamped : pend_q;
    assign phase_end   = (cnt_q == half_q - CNT_W'(1));
    // A high phase begins from IDLE, or back-to-back after a completed period.
    assign start       = en && ((state_q == IDLE) || ((state_q == LOW) && phase_end));

    // Two-flop resynchroniser for the asynchronous mic data pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pdm_data;
            sync2_q <= sync1_q;
        end
    end

    // Phase FSM: counts each phase, captures data at phase ends, applies config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= DEF_H;
            pend_q  <= DEF_H;
            busy_q  <= 1'b0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            dr_q    <= 1'b0;
            dl_q    <= 1'b0;
            pv_q    <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            pv_q   <= 1'b0;

            if (cfg_load) begin
                pend_q <= cfg_clamped;
                busy_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    clk_q <= 1'b0;
                end
                HIGH: begin
                    if (phase_end) begin
                        cnt_q   <= '0;
                        dr_q    <= sync2_q;
                        state_q <= LOW;
                        clk_q   <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        cnt_q   <= '0;
                        dl_q    <= sync2_q;
                        pv_q    <= 1'b1;
                        state_q <= IDLE;
                        clk_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    clk_q   <= 1'b0;
                end
            endcase

            // Placed last so it overrides the IDLE/LOW outcomes above.
            if (start) begin
                half_q  <= half_d;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
                state_q <= HIGH;
                clk_q   <= 1'b1;
                rise_q  <= 1'b1;
            end
        end
    end

    assign cfg_busy   = busy_q;
    assign pdm_clk    = clk_q;
    assign rise_stb   = rise_q;
    assign fall_stb   = fall_q;
    assign data_r     = dr_q;
    assign data_l     = dl_q;
    assign pair_valid = pv_q;

endmodule
